// File: rtl/parity_frame_checker.sv
// parity_frame_checker: deserialises DATA_W data bits plus a trailing parity bit and flags XOR parity mismatches
//   clk, rst_n               : clock, asynchronous active-low reset
//   frame_start, bit_in,
//   bit_valid                : frame start pulse, serial bit (LSB first, then parity), bit strobe
//   busy                     : receiving data or parity bit
//   data_out, data_valid,
//   parity_err               : last word, 1-cycle update pulse, parity result of last word
//   err_count                : saturating count of bad frames, only when ERR_COUNT_EN is defined (else 0)
module parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_count
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                acc_q, acc_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                perr_q, perr_d;
    logic                dv_q, dv_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        dv_d    = 1'b0;
        // frame_start has priority over any bit arriving on the same edge
        if (frame_start) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
            sh_d    = '0;
        end else if (bit_valid && state_q == DATA) begin
            sh_d[cnt_q] = bit_in;
            acc_d       = acc_q ^ bit_in;
            cnt_d       = cnt_q + CW'(1);
            state_d     = (cnt_q == CW'(DATA_W - 1)) ? PAR : DATA;
        end else if (bit_valid && state_q == PAR) begin
            state_d = IDLE;
            dout_d  = sh_q;
            perr_d  = acc_q ^ bit_in ^ ODD;
            dv_d    = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            sh_q    <= '0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            dv_q    <= dv_d;
        end
    end
`ifdef ERR_COUNT_EN
    logic [CNT_W-1:0] ec_q;
    // counts alongside the data_valid update so err_count matches parity_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ec_q <= '0;
        else if (dv_d && perr_d && ec_q != '1) ec_q <= ec_q + CNT_W'(1);
    end
    assign err_count = ec_q;
`else
    assign err_count = '0;
`endif
    assign busy       = state_q != IDLE;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: table vectors, corner sequences and random stimulus against a bit-queue reference model
module tb_parity_frame_checker;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam bit OD = 1'b0;
    logic clk = 0, rst_n = 0, frame_start = 0, bit_in = 0, bit_valid = 0;
    logic busy, data_valid, parity_err;
    logic [DW-1:0] data_out;
    logic [CW-1:0] err_count;
    logic f2 = 0, b2 = 0, v2 = 0, busy2, dv2, pe2;
    logic [DW-1:0] dout2;
    logic [1:0] ec2;
    always #5 clk = ~clk;
    parity_frame_checker #(.DATA_W(DW), .CNT_W(CW), .ODD(OD)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy), .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err), .err_count(err_count)
    );
    parity_frame_checker #(.DATA_W(DW), .CNT_W(2), .ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .frame_start(f2), .bit_in(b2), .bit_valid(v2),
        .busy(busy2), .data_out(dout2), .data_valid(dv2), .parity_err(pe2), .err_count(ec2)
    );
    typedef struct {
        logic [7:0] d;
        logic       p;
        logic [7:0] xd;
        logic       xe;
    } vec_t;
    vec_t tbl[7];
    int checks = 0, errors = 0;
    bit in_frame;
    logic q[$];
    logic [DW-1:0] m_dout;
    logic m_dv, m_pe;
    int m_ec;
    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask
    function automatic logic [31:0] got_vec();
        return 32'({busy, data_out, data_valid, parity_err, err_count});
    endfunction
    function automatic logic [31:0] exp_vec();
        return 32'({in_frame, m_dout, m_dv, m_pe, CW'(m_ec)});
    endfunction
    task automatic reset_model();
        in_frame = 0;
        q.delete();
        m_dout = '0;
        m_dv = 0;
        m_pe = 0;
        m_ec = 0;
    endtask
    // one clock of stimulus; the model collects bits in a queue and judges the frame once the parity bit arrives
    task automatic step(logic fs, logic bv, logic bi, string n = "step");
        logic [DW-1:0] w;
        int ones;
        frame_start = fs;
        bit_valid = bv;
        bit_in = bi;
        @(posedge clk);
        m_dv = 0;
        if (fs) begin
            in_frame = 1;
            q.delete();
        end else if (bv && in_frame) begin
            if (q.size() < DW) q.push_back(bi);
            else begin
                for (int i = 0; i < DW; i++) w[i] = q[i];
                ones = $countones(w) + int'(bi) + int'(OD);
                m_dout = w;
                m_pe = ones[0];
                m_dv = 1;
                in_frame = 0;
`ifdef ERR_COUNT_EN
                if (m_pe && m_ec < (1 << CW) - 1) m_ec++;
`endif
            end
        end
        #1 chk(n, got_vec(), exp_vec());
    endtask
    task automatic send(logic [7:0] d, logic p);
        step(1, 0, 0, "start");
        for (int i = 0; i < DW; i++) step(0, 1, d[i], "data_bit");
        step(0, 1, p, "parity_bit");
    endtask
    task automatic step2(logic fs, logic bv, logic bi);
        f2 = fs;
        v2 = bv;
        b2 = bi;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [7:0] gd;
        int xc;
        tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
        tbl[2] = '{8'h07, 1'b1, 8'h07, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 8'h00, 1'b1};
        tbl[5] = '{8'h80, 1'b0, 8'h80, 1'b1};
        tbl[6] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
        reset_model();
        #3 chk("reset_outputs", got_vec(), 32'h0);
        chk("reset_outputs_odd", 32'({busy2, dout2, dv2, pe2, ec2}), 32'h0);
        #10 rst_n = 1;
        for (int k = 0; k < 7; k++) begin
            send(tbl[k].d, tbl[k].p);
            chk("tbl_data", 32'(data_out), 32'(tbl[k].xd));
            chk("tbl_perr", 32'(parity_err), 32'(tbl[k].xe));
            chk("tbl_valid", 32'(data_valid), 32'h1);
            step(0, 0, 0, "valid_drop");
            chk("tbl_hold", 32'(data_out), 32'(tbl[k].xd));
        end
        step(1, 0, 0, "abort_start");
        for (int i = 0; i < 3; i++) step(0, 1, 1, "abort_bit");
        send(8'h01, 1);
        chk("abort_data", 32'({data_out, parity_err, data_valid}), 32'({8'h01, 1'b0, 1'b1}));
        step(0, 0, 0, "abort_drop");
        for (int i = 0; i < 3; i++) step(0, 1, 1, "idle_bit");
        chk("idle_busy", 32'(busy), 32'h0);
        gd = 8'h3C;
        step(1, 1, 1, "start_wins");
        for (int i = 0; i < DW; i++) begin
            step(0, 0, 1, "gap");
            step(0, 1, gd[i], "gap_bit");
        end
        step(0, 0, 0, "gap");
        chk("gap_busy", 32'(busy), 32'h1);
        step(0, 1, 0, "gap_parity");
        chk("gap_data", 32'({data_out, parity_err, busy}), 32'({8'h3C, 1'b0, 1'b0}));
        step(1, 0, 0, "rst_start");
        for (int i = 0; i < 5; i++) step(0, 1, 1, "rst_bit");
        #3 rst_n = 0;
        #1 chk("async_reset", got_vec(), 32'h0);
        reset_model();
        @(posedge clk);
        #2 rst_n = 1;
        send(8'hFF, 0);
        chk("after_reset", 32'({data_out, parity_err, data_valid}), 32'({8'hFF, 1'b0, 1'b1}));
        for (int i = 0; i < 800; i++)
            step(logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), "random");
        for (int k = 0; k < 4; k++) begin
            step2(1, 0, 0);
            for (int i = 0; i < DW; i++) step2(0, 1, 0);
            step2(0, 1, 0);
`ifdef ERR_COUNT_EN
            xc = (k < 3) ? k + 1 : 3;
`else
            xc = 0;
`endif
            chk("odd_perr", 32'({dv2, pe2, dout2}), 32'({1'b1, 1'b1, 8'h00}));
            chk("odd_count", 32'(ec2), 32'(xc));
            step2(0, 0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
